// File: rtl/rv_ctrl_pkg.sv
// Shared types and constants for the RV32I multi-cycle sequencer.
package rv_ctrl_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned STATE_W = 3;
    localparam int unsigned TMO_W   = 8;

    typedef enum logic [STATE_W-1:0] {
        CTRL_IDLE   = 3'd0,
        CTRL_FETCH  = 3'd1,
        CTRL_DECODE = 3'd2,
        CTRL_EXEC   = 3'd3,
        CTRL_MEM    = 3'd4,
        CTRL_WB     = 3'd5,
        CTRL_HALT   = 3'd6,
        CTRL_FAULT  = 3'd7
    } ctrl_state_e;

    localparam logic [XLEN-1:0]  INST_NOP            = 32'h0000_0013;
    localparam logic [XLEN-1:0]  RESET_PC_DEFAULT    = 32'h0000_0000;
    localparam logic [TMO_W-1:0] MEM_TIMEOUT_DEFAULT = 8'd255;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Sequencer bus bundle: instruction/data memory handshakes, decoder
// feedback and status.
//   master : the sequencer (drives requests, IR/PC, GRF strobe, status)
//   slave  : memories, decoder and jump logic (drive acks and controls)
interface multicycle_ctrl_if;
    import rv_ctrl_pkg::*;

    logic                 i_Start_1;
    logic                 o_IMemReq_1;
    logic [XLEN-1:0]      o_IMemAddr_32;
    logic                 i_IMemAck_1;
    logic [XLEN-1:0]      i_IMemRData_32;
    logic [XLEN-1:0]      o_Inst_32;
    logic [XLEN-1:0]      o_PC_32;
    logic                 i_Load_1;
    logic                 i_Store_1;
    logic                 i_GRFWen_1;
    logic                 i_Halt_1;
    logic                 i_Jump_1;
    logic [XLEN-1:0]      i_JumpTarget_32;
    logic                 o_DMemReq_1;
    logic                 o_DMemWe_1;
    logic                 i_DMemAck_1;
    logic                 o_GRFWen_1;
    logic [STATE_W-1:0]   o_State_3;
    logic                 o_Halted_1;
    logic                 o_Fault_1;
    logic [XLEN-1:0]      o_InstRet_32;

    modport master (
        input  i_Start_1, i_IMemAck_1, i_IMemRData_32, i_Load_1, i_Store_1,
               i_GRFWen_1, i_Halt_1, i_Jump_1, i_JumpTarget_32, i_DMemAck_1,
        output o_IMemReq_1, o_IMemAddr_32, o_Inst_32, o_PC_32, o_DMemReq_1,
               o_DMemWe_1, o_GRFWen_1, o_State_3, o_Halted_1, o_Fault_1,
               o_InstRet_32
    );

    modport slave (
        output i_Start_1, i_IMemAck_1, i_IMemRData_32, i_Load_1, i_Store_1,
               i_GRFWen_1, i_Halt_1, i_Jump_1, i_JumpTarget_32, i_DMemAck_1,
        input  o_IMemReq_1, o_IMemAddr_32, o_Inst_32, o_PC_32, o_DMemReq_1,
               o_DMemWe_1, o_GRFWen_1, o_State_3, o_Halted_1, o_Fault_1,
               o_InstRet_32
    );

endinterface

// File: rtl/ctrl_timeout_cnt.sv
// Memory-wait counter.
//   clk, rst_n : clock, async active-low reset (count -> 0)
//   clear      : restart the count (entry into a waiting state)
//   enable     : this cycle is a wait without ack
//   expired    : this waiting cycle brings the count to MEM_TIMEOUT
module ctrl_timeout_cnt
    import rv_ctrl_pkg::*;
#(
    parameter logic [TMO_W-1:0] MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [TMO_W-1:0] count_q;

    // Saturating wait count; clear has priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (enable && (count_q != '1)) begin
            count_q <= count_q + TMO_W'(1);
        end
    end

    // Fire on the wait that would make the count equal MEM_TIMEOUT, so an
    // ack in that same cycle (enable low) still wins.
    assign expired = enable && (count_q == (MEM_TIMEOUT - TMO_W'(1)));

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I sequencer: owns PC/IR, walks FETCH/DECODE/EXEC/MEM/WB,
// arbitrates imem/dmem handshakes, gates the GRF write and traps on bus
// timeout or a misaligned jump target.
//   i_Clk_1, i_RstN_1 : clock, async active-low reset
//   bus (master)      : memory handshakes, decoder controls, IR/PC, status
module multicycle_ctrl
    import rv_ctrl_pkg::*;
#(
    parameter logic [XLEN-1:0]  RESET_PC    = RESET_PC_DEFAULT,
    parameter logic [TMO_W-1:0] MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
    input  logic              i_Clk_1,
    input  logic              i_RstN_1,
    multicycle_ctrl_if.master bus
);

    ctrl_state_e     state_q, state_d;
    logic [XLEN-1:0] pc_q, ir_q, instret_q;
    logic            dmem_we_q;

    logic            imem_req_c, dmem_req_c, grf_wen_c;
    logic            wait_en_c, tmo_clear_c, tmo_expired;
    logic            jump_bad_c;
    logic [XLEN-1:0] jump_tgt_c;
    logic            unused_jump_lsb;

    assign unused_jump_lsb = bus.i_JumpTarget_32[0];

    // Jump target is halfword-forced; a set bit 1 is a misaligned target.
    assign jump_tgt_c = {bus.i_JumpTarget_32[XLEN-1:1], 1'b0};
    assign jump_bad_c = bus.i_Jump_1 && jump_tgt_c[1];

    // State register.
    always_ff @(posedge i_Clk_1 or negedge i_RstN_1) begin
        if (!i_RstN_1) begin
            state_q <= CTRL_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and per-state strobes.
    always_comb begin
        state_d    = state_q;
        imem_req_c = 1'b0;
        dmem_req_c = 1'b0;
        grf_wen_c  = 1'b0;
        wait_en_c  = 1'b0;
        case (state_q)
            CTRL_IDLE: begin
                if (bus.i_Start_1) state_d = CTRL_FETCH;
            end
            CTRL_FETCH: begin
                imem_req_c = 1'b1;
                wait_en_c  = !bus.i_IMemAck_1;
                if (bus.i_IMemAck_1)  state_d = CTRL_DECODE;
                else if (tmo_expired) state_d = CTRL_FAULT;
            end
            CTRL_DECODE: begin
                state_d = CTRL_EXEC;
            end
            CTRL_EXEC: begin
                if (bus.i_Halt_1)                        state_d = CTRL_HALT;
                else if (bus.i_Load_1 || bus.i_Store_1) state_d = CTRL_MEM;
                else                                     state_d = CTRL_WB;
            end
            CTRL_MEM: begin
                dmem_req_c = 1'b1;
                wait_en_c  = !bus.i_DMemAck_1;
                if (bus.i_DMemAck_1)  state_d = CTRL_WB;
                else if (tmo_expired) state_d = CTRL_FAULT;
            end
            CTRL_WB: begin
                if (jump_bad_c) begin
                    state_d = CTRL_FAULT;
                end else begin
                    grf_wen_c = bus.i_GRFWen_1 || bus.i_Load_1;
                    state_d   = CTRL_FETCH;
                end
            end
            CTRL_HALT:  state_d = CTRL_HALT;
            CTRL_FAULT: state_d = CTRL_FAULT;
            default:    state_d = CTRL_FAULT;
        endcase
    end

    // Restart the wait count whenever a handshake state is entered.
    assign tmo_clear_c = ((state_d == CTRL_FETCH) || (state_d == CTRL_MEM)) &&
                         (state_d != state_q);

    ctrl_timeout_cnt #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_timeout (
        .clk     (i_Clk_1),
        .rst_n   (i_RstN_1),
        .clear   (tmo_clear_c),
        .enable  (wait_en_c),
        .expired (tmo_expired)
    );

    // PC, IR, retire count and latched store flag.
    always_ff @(posedge i_Clk_1 or negedge i_RstN_1) begin
        if (!i_RstN_1) begin
            pc_q      <= RESET_PC;
            ir_q      <= INST_NOP;
            instret_q <= '0;
            dmem_we_q <= 1'b0;
        end else begin
            if ((state_q == CTRL_FETCH) && bus.i_IMemAck_1) begin
                ir_q <= bus.i_IMemRData_32;
            end
            if ((state_q == CTRL_EXEC) && (state_d == CTRL_MEM)) begin
                dmem_we_q <= bus.i_Store_1;
            end
            if ((state_q == CTRL_WB) && !jump_bad_c) begin
                pc_q      <= bus.i_Jump_1 ? jump_tgt_c : (pc_q + XLEN'(4));
                instret_q <= instret_q + XLEN'(1);
            end
        end
    end

    assign bus.o_IMemReq_1   = imem_req_c;
    assign bus.o_IMemAddr_32 = pc_q;
    assign bus.o_Inst_32     = ir_q;
    assign bus.o_PC_32       = pc_q;
    assign bus.o_DMemReq_1   = dmem_req_c;
    assign bus.o_DMemWe_1    = dmem_we_q && (state_q == CTRL_MEM);
    assign bus.o_GRFWen_1    = grf_wen_c;
    assign bus.o_State_3     = STATE_W'(state_q);
    assign bus.o_Halted_1    = (state_q == CTRL_HALT);
    assign bus.o_Fault_1     = (state_q == CTRL_FAULT);
    assign bus.o_InstRet_32  = instret_q;

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Multi-cycle sequencer for the RV32I core.
- Owns the PC and instruction register (IR) and feeds the IR to the combinational instruction decoder.
- Sequences fetch / decode / execute / memory / writeback around the shared decoder, ALU and GRF.
- Arbitrates the single instruction-memory and data-memory request/ack handshakes, gates the GRF write enable, and traps on bus timeout or a misaligned jump target.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
MEM_TIMEOUT, 8'd255, max cycles waiting for a memory ack before FAULT (1..255)

Ports:
i_Clk_1  in  1  clock, rising edge
i_RstN_1  in  1  asynchronous active-low reset
i_Start_1  in  1  leave IDLE and begin fetching
o_IMemReq_1  out  1  instruction fetch request
o_IMemAddr_32  out  32  fetch address (= PC)
i_IMemAck_1  in  1  fetch data valid
i_IMemRData_32  in  32  fetched instruction
o_Inst_32  out  32  IR contents, to decoder
o_PC_32  out  32  current PC, to decoder
i_Load_1  in  1  decoder: load
i_Store_1  in  1  decoder: store
i_GRFWen_1  in  1  decoder: register writeback
i_Halt_1  in  1  decoder: ECALL/EBREAK
i_Jump_1  in  1  jump/branch control: redirect (JAL, JALR or taken branch)
i_JumpTarget_32  in  32  redirect target
o_DMemReq_1  out  1  data memory request
o_DMemWe_1  out  1  data memory write (store)
i_DMemAck_1  in  1  data access complete
o_GRFWen_1  out  1  gated GRF write strobe
o_State_3  out  3  current FSM state
o_Halted_1  out  1  in HALT
o_Fault_1  out  1  in FAULT
o_InstRet_32  out  32  retired-instruction count

Behaviour:
Reset (async, i_RstN_1=0):
- state=IDLE, PC=RESET_PC, IR=32'h0000_0013 (NOP), InstRet=0, timeout count=0.
- All request, write and status outputs are 0 immediately; any in-flight request is dropped at once.

State encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6, FAULT=7.

Per-state behaviour:
- IDLE: all requests low; i_Start_1=1 -> FETCH.
- FETCH: o_IMemReq_1=1 held until ack. On i_IMemAck_1: IR<=i_IMemRData_32 -> DECODE.
- DECODE: exactly one cycle (decoder and GRF read settle) -> EXEC.
- EXEC: exactly one cycle.
  - i_Halt_1 -> HALT; the instruction does not retire.
  - else i_Load_1|i_Store_1 -> MEM; o_DMemWe_1 latched from i_Store_1 on entry.
  - else -> WB.
- MEM: o_DMemReq_1=1 held, o_DMemWe_1 constant until i_DMemAck_1 -> WB.
- WB: exactly one cycle.
  - o_GRFWen_1 = i_GRFWen_1|i_Load_1 (single-cycle pulse, never asserted in any other state).
  - PC update: if i_Jump_1, target t = {i_JumpTarget_32[31:1],1'b0}. If t[1]=1 -> FAULT, with no PC update, no retire and o_GRFWen_1 forced 0. Otherwise PC<=t.
  - If i_Jump_1=0, PC<=PC+4, wrapping mod 2^32.
  - On a successful WB: InstRet+=1 (wraps mod 2^32) -> FETCH.
- HALT / FAULT: sticky until reset; all requests low; o_Halted_1 / o_Fault_1 = 1.

Timeout:
- The counter clears on entry to FETCH/MEM and increments each waiting cycle without ack.
- When the count reaches MEM_TIMEOUT with no ack -> FAULT.
- Ack and timeout in the same cycle: ack wins.

Handshake rules:
- An ack while the matching request is low is ignored.
- Request and address/we are stable while the request is high.
- A request deasserts in the cycle after the ack is sampled.

Latency with 1-cycle ack: ALU/jump instruction 4 cycles (FETCH, DECODE, EXEC, WB); load/store 5 cycles.

IR and PC are stable from DECODE through WB, so the decoder outputs are stable when sampled.

Decomposition:
- Package rv_ctrl_pkg:
  - state encodings CTRL_IDLE..CTRL_FAULT (3 bits)
  - INST_NOP = 32'h0000_0013
  - default RESET_PC
  - default MEM_TIMEOUT
- Sub-module ctrl_timeout_cnt: 8-bit wait counter.
  - Inputs: clear, enable (waiting without ack).
  - Output: expired when count == MEM_TIMEOUT.
  - Reset: count=0.

Test Plan:
- Reset, pulse i_Start_1, memory acks next cycle, IR data 32'h00500093 (addi), i_GRFWen_1=1 -> o_GRFWen_1 pulses once in WB; PC 0->4; InstRet=1; fetch at 0 is 4 cycles after first request to second request.
- Load, i_Load_1=1, DMem ack after 3 wait cycles -> o_DMemReq_1 high 4 cycles; o_DMemWe_1=0; o_GRFWen_1 pulses in WB; PC+=4.
- Store, i_Store_1=1, i_GRFWen_1=0 -> o_DMemWe_1=1 throughout MEM; o_GRFWen_1 never asserted; InstRet increments.
- Jump path:
  - i_Jump_1=1, target 32'h0000_0101 -> PC=32'h0000_0100.
  - target 32'h0000_0102 -> FAULT, o_Fault_1=1, PC unchanged, InstRet unchanged.
- MEM_TIMEOUT=4, IMem never acks -> FAULT after 4 waiting cycles; o_IMemReq_1=0 afterwards; ack on the 4th cycle instead proceeds to DECODE.
- i_Halt_1 in EXEC -> HALT sticky, no retire. Separately, assert i_RstN_1=0 mid-MEM -> o_DMemReq_1 drops immediately, state=IDLE, PC=RESET_PC.
